// File: rtl/video_feedback_mixer.sv
// Purpose: blends the live pixel with the DRAM feedback pixel into a display stream and a recirculation stream.
// Latency: fixed 3 cycles on every output (S1 capture, S2 gain scaling, S3 combine).
// Backpressure: none; one pixel is accepted every cycle and the pipeline never stalls.
module video_feedback_mixer #(
  parameter int NCH        = 3,
  parameter int W          = 8,
  parameter int FB_MAX     = 1000,
  parameter int LATCH_LINE = 720,
  parameter int H_BITS     = 11,
  parameter int V_BITS     = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [H_BITS-1:0]   h_count_in,
  input  logic [V_BITS-1:0]   v_count_in,
  input  logic                active_draw_in,
  input  logic [NCH*W-1:0]    pixel_in,
  input  logic [NCH*W-1:0]    pixel_from_feedback,
  input  logic [9:0]          wet,
  input  logic [9:0]          feedback,
  input  logic [1:0]          mode,
  input  logic                clear_req,
  output logic [H_BITS-1:0]   h_count_out,
  output logic [V_BITS-1:0]   v_count_out,
  output logic                active_draw_out,
  output logic [NCH*W-1:0]    pixel_out,
  output logic [NCH*W-1:0]    pixel_to_feedback,
  output logic                clear_busy
);

  localparam int PW = NCH * W;
  localparam logic [1:0] MODE_MAX     = 2'd0;
  localparam logic [1:0] MODE_ADD_SAT = 2'd1;
  localparam logic [1:0] MODE_AVG     = 2'd2;
  // Gain cap kept below 1024 so the recirculated image always decays.
  localparam logic [9:0] FB_CAP = (FB_MAX > 1023) ? 10'd1023 : 10'(FB_MAX);

  typedef enum logic [1:0] {CLR_IDLE, CLR_ARMED, CLR_CLEARING} clr_state_t;

  typedef struct packed {
    logic [H_BITS-1:0] h;
    logic [V_BITS-1:0] v;
    logic              act;
  } pos_t;

  // Scale one channel by a g/1024 gain; the W+10 bit product is truncated.
  function automatic logic [W-1:0] scale(input logic [W-1:0] pix, input logic [9:0] gain);
    logic [W+9:0] prod;
    prod = {10'b0, pix} * {{W{1'b0}}, gain};
    return W'(prod >> 10);
  endfunction

  // Combine scaled feedback s with live channel c under the frame's mode.
  function automatic logic [W-1:0] combine(input logic [1:0] m, input logic [W-1:0] s,
                                           input logic [W-1:0] c);
    logic [W:0]   sum;
    logic [W-1:0] res;
    sum = {1'b0, s} + {1'b0, c};
    case (m)
      MODE_MAX:     res = (s > c) ? s : c;
      MODE_ADD_SAT: res = sum[W] ? {W{1'b1}} : sum[W-1:0];
      MODE_AVG:     res = W'((sum + {{W{1'b0}}, 1'b1}) >> 1);
      default:      res = c;
    endcase
    return res;
  endfunction

  logic       fb_edge;
  logic [9:0] wet_l, fb_l, fb_eff;
  logic [1:0] mode_l;
  clr_state_t clr_state, clr_state_nxt;

  assign fb_edge = (h_count_in == '0) && (v_count_in == V_BITS'(LATCH_LINE));
  assign fb_eff  = (fb_l > FB_CAP) ? FB_CAP : fb_l;

  // Frame-boundary shadow registers so gains and mode never change mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      wet_l  <= '0;
      fb_l   <= '0;
      mode_l <= MODE_MAX;
    end else if (fb_edge) begin
      wet_l  <= wet;
      fb_l   <= feedback;
      mode_l <= mode;
    end
  end

  // Clear FSM state and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_state  <= CLR_IDLE;
      clear_busy <= 1'b0;
    end else begin
      clr_state  <= clr_state_nxt;
      clear_busy <= (clr_state_nxt != CLR_IDLE);
    end
  end

  // Next state: a request arms, the next boundary starts the flush, the one after ends it.
  always_comb begin
    clr_state_nxt = clr_state;
    case (clr_state)
      CLR_IDLE:     if (clear_req) clr_state_nxt = CLR_ARMED;
      CLR_ARMED:    if (fb_edge)   clr_state_nxt = CLR_CLEARING;
      CLR_CLEARING: if (fb_edge)   clr_state_nxt = CLR_IDLE;
      default:      clr_state_nxt = CLR_IDLE;
    endcase
  end

  // S1: capture the pixel together with the gains, mode and clearing flag it will use.
  logic          s1_vld, s1_clr;
  pos_t          s1_pos;
  logic [PW-1:0] s1_live, s1_fbpix;
  logic [9:0]    s1_wet, s1_fbg;
  logic [1:0]    s1_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_pos   <= '0;
      s1_live  <= '0;
      s1_fbpix <= '0;
      s1_wet   <= '0;
      s1_fbg   <= '0;
      s1_mode  <= MODE_MAX;
      s1_clr   <= 1'b0;
    end else begin
      s1_vld   <= 1'b1;
      s1_pos   <= '{h: h_count_in, v: v_count_in, act: active_draw_in};
      s1_live  <= pixel_in;
      s1_fbpix <= pixel_from_feedback;
      s1_wet   <= wet_l;
      s1_fbg   <= fb_eff;
      s1_mode  <= mode_l;
      s1_clr   <= (clr_state == CLR_CLEARING);
    end
  end

  // S2 combinational: per-channel gain scaling, feedback forced to zero while flushing.
  logic [PW-1:0] fbpix_eff, ws_c, fs_c;
  assign fbpix_eff = s1_clr ? '0 : s1_fbpix;

  always_comb begin
    ws_c = '0;
    fs_c = '0;
    for (int i = 0; i < NCH; i++) begin
      ws_c[i*W +: W] = scale(fbpix_eff[i*W +: W], s1_wet);
      fs_c[i*W +: W] = scale(fbpix_eff[i*W +: W], s1_fbg);
    end
  end

  logic          s2_vld;
  pos_t          s2_pos;
  logic [PW-1:0] s2_live, s2_ws, s2_fs;
  logic [1:0]    s2_mode;

  // S2 register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      s2_pos  <= '0;
      s2_live <= '0;
      s2_ws   <= '0;
      s2_fs   <= '0;
      s2_mode <= MODE_MAX;
    end else begin
      s2_vld  <= s1_vld;
      s2_pos  <= s1_pos;
      s2_live <= s1_live;
      s2_ws   <= ws_c;
      s2_fs   <= fs_c;
      s2_mode <= s1_mode;
    end
  end

  // S3 combinational: mode-dependent mix for both output streams.
  logic [PW-1:0] po_c, pf_c;

  always_comb begin
    po_c = '0;
    pf_c = '0;
    for (int i = 0; i < NCH; i++) begin
      po_c[i*W +: W] = combine(s2_mode, s2_ws[i*W +: W], s2_live[i*W +: W]);
      pf_c[i*W +: W] = combine(s2_mode, s2_fs[i*W +: W], s2_live[i*W +: W]);
    end
  end

  // S3 output registers; an empty stage after reset drives zeros.
  always_ff @(posedge clk) begin
    if (rst || !s2_vld) begin
      h_count_out       <= '0;
      v_count_out       <= '0;
      active_draw_out   <= 1'b0;
      pixel_out         <= '0;
      pixel_to_feedback <= '0;
    end else begin
      h_count_out       <= s2_pos.h;
      v_count_out       <= s2_pos.v;
      active_draw_out   <= s2_pos.act;
      pixel_out         <= po_c;
      pixel_to_feedback <= pf_c;
    end
  end

endmodule

// File: tb/tb_video_feedback_mixer.sv
// Purpose: self-checking bench for video_feedback_mixer, directed cases plus randomized raster.
// Latency: expected outputs are delayed three samples through a reference delay line.
// Backpressure: not applicable; one pixel is driven every cycle.
module tb_video_feedback_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] h_count_in;
  logic [9:0]  v_count_in;
  logic        active_draw_in;
  logic [23:0] pixel_in, pixel_from_feedback;
  logic [9:0]  wet, feedback;
  logic [1:0]  mode;
  logic        clear_req;
  logic [10:0] h_count_out;
  logic [9:0]  v_count_out;
  logic        active_draw_out;
  logic [23:0] pixel_out, pixel_to_feedback;
  logic        clear_busy;

  video_feedback_mixer dut (
    .clk(clk), .rst(rst),
    .h_count_in(h_count_in), .v_count_in(v_count_in), .active_draw_in(active_draw_in),
    .pixel_in(pixel_in), .pixel_from_feedback(pixel_from_feedback),
    .wet(wet), .feedback(feedback), .mode(mode), .clear_req(clear_req),
    .h_count_out(h_count_out), .v_count_out(v_count_out), .active_draw_out(active_draw_out),
    .pixel_out(pixel_out), .pixel_to_feedback(pixel_to_feedback), .clear_busy(clear_busy)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] P200 = 24'hc8c8c8;
  localparam logic [23:0] P80  = 24'h505050;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame-indexed gains and flush, expected results in a 3-deep delay line.
  typedef struct {
    logic [23:0] po, pf;
    logic [10:0] h;
    logic [9:0]  v;
    logic        a;
  } exp_t;

  exp_t pipe [3];
  int   m_wet, m_fb, m_mode, m_idx, m_flush_f;
  bit   m_pend, m_busy;

  function automatic int mix(input int m, input int s, input int c);
    case (m)
      0:       return (s > c) ? s : c;
      1:       return (s + c > 255) ? 255 : s + c;
      2:       return (s + c + 1) / 2;
      default: return c;
    endcase
  endfunction

  task automatic model_reset_pipe();
    for (int i = 0; i < 3; i++) begin
      pipe[i].po = '0; pipe[i].pf = '0; pipe[i].h = '0; pipe[i].v = '0; pipe[i].a = 1'b0;
    end
  endtask

  task automatic model_step();
    exp_t e;
    int   fbe, f, c, ws, fs;
    bit   edge_now, flushed;
    if (rst) begin
      model_reset_pipe();
      m_wet = 0; m_fb = 0; m_mode = 0; m_pend = 0; m_busy = 0;
      return;
    end
    edge_now = (h_count_in == 0) && (v_count_in == 720);
    flushed  = m_pend && (m_idx == m_flush_f);
    fbe      = (m_fb > 1000) ? 1000 : m_fb;
    e.po = '0; e.pf = '0;
    e.h = h_count_in; e.v = v_count_in; e.a = active_draw_in;
    for (int ch = 0; ch < 3; ch++) begin
      c  = int'(pixel_in[8*ch +: 8]);
      f  = flushed ? 0 : int'(pixel_from_feedback[8*ch +: 8]);
      ws = (f * m_wet) / 1024;
      fs = (f * fbe) / 1024;
      e.po[8*ch +: 8] = 8'(mix(m_mode, ws, c));
      e.pf[8*ch +: 8] = 8'(mix(m_mode, fs, c));
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
    if (edge_now) begin
      m_idx++;
      m_wet = int'(wet); m_fb = int'(feedback); m_mode = int'(mode);
    end
    if (clear_req && !m_busy) begin
      m_pend    = 1;
      m_flush_f = m_idx + 1;   // the first complete frame after the request
    end
    m_busy = m_pend && (m_idx <= m_flush_f);
    if (!m_busy) m_pend = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("pixel_out", pixel_out, pipe[2].po);
    check("pixel_to_feedback", pixel_to_feedback, pipe[2].pf);
    check("h_count_out", h_count_out, pipe[2].h);
    check("v_count_out", v_count_out, pipe[2].v);
    check("active_draw_out", active_draw_out, pipe[2].a);
    check("clear_busy", clear_busy, m_busy);
  endtask

  task automatic px(input int v, input int h, input logic [23:0] live, input logic [23:0] fbp,
                    input bit creq);
    v_count_in          = 10'(v);
    h_count_in          = 11'(h);
    active_draw_in      = (h % 7) != 5;
    pixel_in            = live;
    pixel_from_feedback = fbp;
    clear_req           = creq;
    cycle();
  endtask

  task automatic hold(input int v, input int n, input logic [23:0] live, input logic [23:0] fbp);
    for (int k = 1; k <= n; k++) px(v, k, live, fbp, 1'b0);
  endtask

  initial begin
    int h, v;
    model_reset_pipe();
    m_idx = 0; m_flush_f = 0; m_pend = 0; m_busy = 0;
    m_wet = 0; m_fb = 0; m_mode = 0;
    rst = 1'b1; wet = '0; feedback = '0; mode = '0; clear_req = 1'b0;

    // Reset state
    for (int k = 0; k < 3; k++) px(10, k + 1, P80, P200, 1'b0);
    check("reset_pixel_out", pixel_out, 0);
    check("reset_clear_busy", clear_busy, 0);
    rst = 1'b0;

    // MAX with feedback clamped to 1000
    wet = 10'd512; feedback = 10'd1023; mode = 2'd0;
    px(720, 0, P80, P200, 1'b0);
    hold(0, 4, P80, P200);
    check("max_po", pixel_out, 24'h646464);
    check("max_pf", pixel_to_feedback, 24'hc3c3c3);

    // ADD_SAT
    wet = 10'd1023; feedback = 10'd0; mode = 2'd1;
    px(720, 0, P200, P200, 1'b0);
    hold(0, 4, P200, P200);
    check("addsat_po", pixel_out, 24'hffffff);
    check("addsat_pf", pixel_to_feedback, 24'hc8c8c8);

    // AVG then BYPASS
    wet = 10'd512; feedback = 10'd0; mode = 2'd2;
    px(720, 0, P80, P200, 1'b0);
    hold(0, 4, P80, P200);
    check("avg_po", pixel_out, 24'h5a5a5a);
    mode = 2'd3;
    px(720, 0, P80, P200, 1'b0);
    hold(0, 4, P80, P200);
    check("bypass_po", pixel_out, P80);
    check("bypass_pf", pixel_to_feedback, P80);

    // Mid-frame gain change waits for the boundary
    wet = 10'd512; feedback = 10'd1023; mode = 2'd0;
    px(720, 0, P80, P200, 1'b0);
    hold(99, 4, P80, P200);
    wet = 10'd0;
    hold(100, 4, P80, P200);
    check("midframe_hold", pixel_out, 24'h646464);
    px(720, 0, P80, P200, 1'b0);
    px(720, 1, P80, P200, 1'b0);
    px(720, 2, P80, P200, 1'b0);
    check("edge_pixel_old_gain", pixel_out, 24'h646464);
    px(720, 3, P80, P200, 1'b0);
    check("first_pixel_new_gain", pixel_out, P80);

    // Clear: arm, ignored re-request, one flushed frame, drop
    px(300, 1, P80, P200, 1'b1);
    check("busy_after_req", clear_busy, 1);
    px(300, 2, P80, P200, 1'b0);
    px(300, 3, P80, P200, 1'b1);
    hold(301, 3, P80, P200);
    check("armed_not_flushed", pixel_to_feedback, 24'hc3c3c3);
    px(720, 0, P80, P200, 1'b0);
    hold(0, 3, P80, P200);
    check("flush_pf_eq_live", pixel_to_feedback, P80);
    hold(400, 5, P80, P200);
    check("flush_busy", clear_busy, 1);
    px(720, 0, P80, P200, 1'b0);
    check("busy_drop", clear_busy, 0);
    hold(0, 3, P80, P200);
    check("after_flush_pf", pixel_to_feedback, 24'hc3c3c3);

    // Reset during CLEARING
    px(300, 1, P80, P200, 1'b1);
    px(720, 0, P80, P200, 1'b0);
    hold(10, 3, P80, P200);
    rst = 1'b1;
    px(50, 0, P80, P200, 1'b0);
    check("rst_mid_po", pixel_out, 0);
    check("rst_mid_pf", pixel_to_feedback, 0);
    check("rst_mid_busy", clear_busy, 0);
    check("rst_mid_h", h_count_out, 0);
    rst = 1'b0;
    px(50, 1, P80, P200, 1'b0);
    px(50, 2, P80, P200, 1'b0);
    check("resume_gap", pixel_to_feedback, 0);
    px(50, 3, P80, P200, 1'b0);
    check("resume_h", h_count_out, 1);
    check("resume_pf", pixel_to_feedback, P80);

    // clear_req coincident with a boundary only arms
    wet = 10'd512; feedback = 10'd1023; mode = 2'd0;
    px(720, 0, P80, P200, 1'b1);
    check("coinc_busy", clear_busy, 1);
    hold(0, 4, P80, P200);
    check("coinc_not_clearing", pixel_to_feedback, 24'hc3c3c3);
    px(720, 0, P80, P200, 1'b0);
    hold(0, 4, P80, P200);
    check("coinc_then_flush", pixel_to_feedback, P80);
    px(720, 0, P80, P200, 1'b0);

    // Randomized raster: 6 pixels per line, lines 715..724, boundary every 60 pixels
    h = 0; v = 715;
    for (int n = 0; n < 2400; n++) begin
      if (h == 0 && $urandom_range(0, 2) == 0) begin
        wet      = 10'($urandom_range(0, 1023));
        feedback = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023))
                                               : 10'($urandom_range(0, 1023));
        mode     = 2'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 399) == 0);
      px(v, h, 24'($urandom), 24'($urandom), $urandom_range(0, 29) == 0);
      h++;
      if (h == 6) begin
        h = 0;
        v = (v == 724) ? 715 : v + 1;
      end
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
